// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU types and default widths for the loader and fetch/ROM path
package cpu_pkg;
  localparam int ADDR_W = 10;
  localparam int WORD_W = 9;
  typedef enum logic [1:0] {IDLE, LOAD, FIN} ld_state_t;
endpackage

// File: rtl/inst_ld_sum.sv
// inst_ld_sum: running modulo-2**W sum of accepted instruction words
// Ports: clk, rst (sync, active-high), clr (restart sum), en (add d), d (word),
//        sum_nxt (sum including this cycle's word; the register value after the edge)
module inst_ld_sum #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum_nxt
);
  logic [W-1:0] sum;
  assign sum_nxt = clr ? '0 : sum + (en ? d : '0);
  always_ff @(posedge clk) sum <= rst ? '0 : sum_nxt;
endmodule

// File: rtl/inst_loader.sv
// inst_loader: streams Length words from a valid/ready source into instruction memory
// Ports: Clk, Reset (sync, active-high); Start/Length load request; InValid/InData/InReady
//        source handshake; WrEn/WrAddr/WrData memory write (1-cycle latency);
//        Busy (fetch hold), Done (sticky completion), ExpSum/Error checksum check.
// Optional: INST_LOADER_CHECKSUM_EN enables the checksum; otherwise Error is tied 0.
module inst_loader
  import cpu_pkg::*;
#(
  parameter int A = ADDR_W,
  parameter int W = WORD_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A:0]   Length,
  input  logic         InValid,
  input  logic [W-1:0] InData,
  output logic         InReady,
  output logic         WrEn,
  output logic [A-1:0] WrAddr,
  output logic [W-1:0] WrData,
  output logic         Busy,
  output logic         Done,
  input  logic [W-1:0] ExpSum,
  output logic         Error
);
  ld_state_t state, state_nxt;
  logic [A-1:0] idx;
  logic [A:0] rem;
  logic hs, go;
  assign InReady = state == LOAD;
  assign hs = InValid && InReady;
  assign go = state == IDLE && Start;
  assign Busy = state != IDLE;
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) state_nxt = Start ? (Length != '0 ? LOAD : FIN) : IDLE;
    else if (state == LOAD) state_nxt = (hs && rem == (A+1)'(1)) ? FIN : LOAD;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      rem <= '0;
      WrEn <= 1'b0;
      WrAddr <= '0;
      WrData <= '0;
      Done <= 1'b0;
    end else begin
      state <= state_nxt;
      WrEn <= hs;
      if (go) begin
        idx <= '0;
        rem <= Length;
        Done <= 1'b0;
      end
      if (hs) begin
        WrAddr <= idx;
        WrData <= InData;
        idx <= idx + 1'b1;
        rem <= rem - 1'b1;
      end
      // a zero-length Start enters FIN immediately, so this must override the clear above
      if (state_nxt == FIN) Done <= 1'b1;
    end
  end
`ifdef INST_LOADER_CHECKSUM_EN
  logic [W-1:0] sum_nxt;
  inst_ld_sum #(.W(W)) u_sum (
    .clk(Clk),
    .rst(Reset),
    .clr(go),
    .en(hs),
    .d(InData),
    .sum_nxt(sum_nxt)
  );
  // sum_nxt already includes the final word accepted on the FIN-entry cycle
  always_ff @(posedge Clk)
    Error <= Reset ? 1'b0 : state_nxt == FIN ? sum_nxt != ExpSum : go ? 1'b0 : Error;
`else
  logic unused_exp;
  assign unused_exp = ^ExpSum;
  assign Error = 1'b0;
`endif
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader
module tb_inst_loader;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [10:0] length = '0;
  logic [8:0] in_data = '0, exp_sum = '0;
  logic in_ready, wr_en, busy, done, error;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;
  int checks = 0, errors = 0;
  int wcnt = 0, asum = 0, c0, s0;
`ifdef INST_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1;
`else
  localparam bit CSUM = 0;
`endif
  inst_loader dut (
    .Clk(clk), .Reset(rst), .Start(start), .Length(length), .InValid(in_valid),
    .InData(in_data), .InReady(in_ready), .WrEn(wr_en), .WrAddr(wr_addr),
    .WrData(wr_data), .Busy(busy), .Done(done), .ExpSum(exp_sum), .Error(error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (wr_en) begin
    wcnt++;
    asum += int'(wr_addr);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [10:0] len);
    start = 1;
    length = len;
    tick;
    start = 0;
  endtask
  task automatic put(input logic [8:0] d);
    in_valid = 1;
    in_data = d;
    tick;
  endtask
  task automatic sum_case(input logic [8:0] es, input bit exp_err);
    exp_sum = es;
    go(11'd2);
    put(9'h100);
    put(9'h101);
    in_valid = 0;
    check("csum_err", {31'b0, error}, {31'b0, exp_err & CSUM});
    tick;
  endtask
  initial begin
    tick;
    tick;
    rst = 0;
    check("rst_outs", {wr_en, busy, done, error, in_ready}, 5'b0);
    check("rst_addr_data", {wr_addr, wr_data}, '0);
    // basic load of three words
    c0 = wcnt;
    go(11'd3);
    check("b_ready_busy", {in_ready, busy, done}, 3'b110);
    put(9'h001);
    check("b_w0", {wr_en, wr_addr, wr_data}, {1'b1, 10'd0, 9'h001});
    put(9'h0A5);
    check("b_w1", {wr_en, wr_addr, wr_data}, {1'b1, 10'd1, 9'h0A5});
    put(9'h1FF);
    check("b_w2", {wr_en, wr_addr, wr_data}, {1'b1, 10'd2, 9'h1FF});
    check("b_fin", {busy, done, in_ready}, 3'b110);
    in_valid = 0;
    tick;
    check("b_idle", {wr_en, busy, done, error}, 4'b0010);
    check("b_count", wcnt - c0, 3);
    // valid gaps: two writes only
    c0 = wcnt;
    go(11'd2);
    check("g_done_clr", {done, busy}, 2'b01);
    put(9'h011);
    check("g_w0", {wr_en, wr_addr, wr_data}, {1'b1, 10'd0, 9'h011});
    in_valid = 0;
    in_data = 9'h022;
    tick;
    check("g_gap0", {31'b0, wr_en}, 0);
    in_data = 9'h033;
    tick;
    check("g_gap1", {31'b0, wr_en}, 0);
    put(9'h044);
    check("g_w1", {wr_en, wr_addr, wr_data}, {1'b1, 10'd1, 9'h044});
    in_valid = 0;
    tick;
    check("g_end", {busy, done}, 2'b01);
    check("g_count", wcnt - c0, 2);
    // valid while idle has no effect
    put(9'h077);
    in_valid = 0;
    check("idle_valid", {wr_en, busy}, 2'b00);
    // zero length
    c0 = wcnt;
    go(11'd0);
    check("z_fin", {busy, done}, 2'b11);
    tick;
    check("z_idle", {busy, done}, 2'b01);
    check("z_count", wcnt - c0, 0);
    // full depth with an ignored Start mid-load
    c0 = wcnt;
    s0 = asum;
    go(11'd1024);
    for (int i = 0; i < 1024; i++) begin
      start = (i == 500);
      length = (i == 500) ? 11'd5 : 11'd1024;
      in_valid = 1;
      in_data = 9'(i);
      tick;
    end
    start = 0;
    in_valid = 0;
    check("f_last", {wr_en, wr_addr, wr_data}, {1'b1, 10'h3FF, 9'h1FF});
    check("f_fin", {busy, done}, 2'b11);
    tick;
    check("f_count", wcnt - c0, 1024);
    check("f_addr_sum", asum - s0, 523776);
    check("f_idle", {wr_en, busy, done}, 3'b001);
    // reset mid-load
    c0 = wcnt;
    go(11'd10);
    for (int i = 0; i < 5; i++) put(9'(i + 8'h30));
    rst = 1;
    in_data = 9'h0EE;
    tick;
    rst = 0;
    in_valid = 0;
    check("r_outs", {wr_en, busy, done, error, in_ready}, 5'b0);
    check("r_addr_data", {wr_addr, wr_data}, '0);
    check("r_count", wcnt - c0, 5);
    go(11'd1);
    put(9'h055);
    check("r_w0", {wr_en, wr_addr, wr_data}, {1'b1, 10'd0, 9'h055});
    in_valid = 0;
    tick;
    check("r_done", {busy, done}, 2'b01);
    // checksum: 0x100 + 0x101 = 0x001 mod 2**9
    sum_case(9'h001, 1'b0);
    sum_case(9'h002, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
